// File: rtl/burst_fifo_writer_if.sv
// Sample-stream, buffer-write and credit signals of the burst FIFO writer.
// master: the writer itself; slave: the surrounding source/buffer/reader.
interface burst_fifo_writer_if #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 100,
  parameter int BURST_LEN = 10
);
  localparam int AW      = $clog2(DEPTH);
  localparam int NBURSTS = DEPTH / BURST_LEN;
  localparam int OW      = $clog2(NBURSTS + 1);

  logic             s_valid;
  logic [WIDTH-1:0] s_data;
  logic             s_ready;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             burst_start;
  logic [AW-1:0]    burst_base;
  logic             rd_burst_done;
  logic [OW-1:0]    outstanding;
  logic             err;

  modport master (
    input  s_valid, s_data, rd_burst_done,
    output s_ready, mem_we, mem_addr, mem_wdata,
           burst_start, burst_base, outstanding, err
  );

  modport slave (
    output s_valid, s_data, rd_burst_done,
    input  s_ready, mem_we, mem_addr, mem_wdata,
           burst_start, burst_base, outstanding, err
  );
endinterface

// File: rtl/burst_fifo_writer.sv
// Write-side controller for the burst FIFO buffers. Packs a valid/ready
// sample stream into BURST_LEN-word bursts inside a DEPTH-word buffer,
// announces each completed burst, and tracks reader credits so unread
// bursts are never overwritten.
// Optional macro BURST_WR_FLUSH_EN: a partial burst idle for TIMEOUT cycles
// is padded with PAD_VALUE and committed.
module burst_fifo_writer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 100,
  parameter int BURST_LEN = 10,
  parameter int TIMEOUT   = 16,
  parameter int PAD_VALUE = 0
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  burst_fifo_writer_if.master   bus
);
  localparam int AW      = $clog2(DEPTH);
  localparam int NBURSTS = DEPTH / BURST_LEN;
  localparam int OW      = $clog2(NBURSTS + 1);
  localparam int CW      = $clog2(BURST_LEN + 1);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] BL_ADDR   = AW'(BURST_LEN);
  localparam logic [AW-1:0] WRAP_OFS  = AW'(DEPTH - BURST_LEN);
  localparam logic [CW-1:0] LAST_WORD = CW'(BURST_LEN - 1);
  localparam logic [OW-1:0] NB_FULL   = OW'(NBURSTS);

  // Reject configurations the address arithmetic cannot handle.
  if ((DEPTH % BURST_LEN) != 0 || TIMEOUT < 1 || PAD_VALUE < 0) begin : g_bad_cfg
    $error("burst_fifo_writer: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    COMMIT
`ifdef BURST_WR_FLUSH_EN
    , PAD
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    word_cnt_q, word_cnt_d;
  logic             mem_we_q, mem_we_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic             burst_start_q, burst_start_d;
  logic [AW-1:0]    burst_base_q, burst_base_d;
  logic [OW-1:0]    outstanding_q, outstanding_d;
  logic             err_q, err_d;
  logic             accept;
  logic             commit;
  logic [AW-1:0]    ptr_next;

`ifdef BURST_WR_FLUSH_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0]    IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] PAD_WORD  = WIDTH'(PAD_VALUE);
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
`endif

  assign accept   = bus.s_valid && (state_q == FILL);
  assign commit   = (state_q == COMMIT);
  assign ptr_next = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + AW'(1);

  // Next-state, buffer write, burst announcement and credit accounting.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    word_cnt_d    = word_cnt_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    burst_start_d = 1'b0;
    burst_base_d  = burst_base_q;
    outstanding_d = outstanding_q;
    err_d         = err_q;
`ifdef BURST_WR_FLUSH_EN
    idle_cnt_d    = idle_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (outstanding_q < NB_FULL) state_d = FILL;
      end
      FILL: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_ptr_q;
          mem_wdata_d = bus.s_data;
          wr_ptr_d    = ptr_next;
          word_cnt_d  = word_cnt_q + CW'(1);
          if (word_cnt_q == LAST_WORD) state_d = COMMIT;
`ifdef BURST_WR_FLUSH_EN
          idle_cnt_d  = '0;
        end else if (word_cnt_q != '0) begin
          if (idle_cnt_q == IDLE_LAST) begin
            state_d    = PAD;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + IW'(1);
          end
`endif
        end
      end
`ifdef BURST_WR_FLUSH_EN
      PAD: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = wr_ptr_q;
        mem_wdata_d = PAD_WORD;
        wr_ptr_d    = ptr_next;
        word_cnt_d  = word_cnt_q + CW'(1);
        if (word_cnt_q == LAST_WORD) state_d = COMMIT;
      end
`endif
      COMMIT: begin
        burst_start_d = 1'b1;
        // wr_ptr already points past the burst; undo BURST_LEN modulo DEPTH.
        burst_base_d  = (wr_ptr_q >= BL_ADDR) ? wr_ptr_q - BL_ADDR
                                              : wr_ptr_q + WRAP_OFS;
        word_cnt_d    = '0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A commit and a returned credit on the same edge cancel out.
    if (commit && !bus.rd_burst_done) begin
      outstanding_d = outstanding_q + OW'(1);
    end else if (!commit && bus.rd_burst_done) begin
      if (outstanding_q == '0) err_d = 1'b1;
      else                     outstanding_d = outstanding_q - OW'(1);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      word_cnt_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      burst_start_q <= 1'b0;
      burst_base_q  <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
`ifdef BURST_WR_FLUSH_EN
      idle_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      word_cnt_q    <= word_cnt_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      burst_start_q <= burst_start_d;
      burst_base_q  <= burst_base_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
`ifdef BURST_WR_FLUSH_EN
      idle_cnt_q    <= idle_cnt_d;
`endif
    end
  end

  assign bus.s_ready     = (state_q == FILL);
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.burst_start = burst_start_q;
  assign bus.burst_base  = burst_base_q;
  assign bus.outstanding = outstanding_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_burst_fifo_writer.sv
// Directed bench for burst_fifo_writer with default geometry (100 words,
// 10-word bursts).
module tb_burst_fifo_writer;
  localparam int WIDTH     = 8;
  localparam int DEPTH     = 100;
  localparam int BURST_LEN = 10;

  logic        wr_clk = 1'b0;
  logic        rst;
  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned total  = 0;
  int unsigned we_seen = 0;
  int unsigned bs_seen = 0;

  always #5 wr_clk = ~wr_clk;

  burst_fifo_writer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN)) bus ();

  burst_fifo_writer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN),
    .TIMEOUT(16), .PAD_VALUE(0)
  ) dut (
    .wr_clk(wr_clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic step();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_s_ready"},     32'(bus.s_ready), 0);
    check({tag, "_mem_we"},      32'(bus.mem_we), 0);
    check({tag, "_mem_addr"},    32'(bus.mem_addr), 0);
    check({tag, "_mem_wdata"},   32'(bus.mem_wdata), 0);
    check({tag, "_burst_start"}, 32'(bus.burst_start), 0);
    check({tag, "_burst_base"},  32'(bus.burst_base), 0);
    check({tag, "_outstanding"}, 32'(bus.outstanding), 0);
    check({tag, "_err"},         32'(bus.err), 0);
  endtask

  // Streams one full burst back-to-back and checks the writes and the
  // announcement; optionally returns a credit on the commit edge.
  task automatic write_burst(input logic [7:0] d0, input int unsigned addr0,
                             input logic rd_at_commit, input int unsigned exp_out);
    for (int n = 0; n < 60 && bus.s_ready !== 1'b1; n++) step();
    check("ready_wait", 32'(bus.s_ready), 1);
    for (int unsigned i = 0; i < BURST_LEN; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = d0 + 8'(i);
      step();
      check("wr_we",   32'(bus.mem_we), 1);
      check("wr_addr", 32'(bus.mem_addr), addr0 + i);
      check("wr_data", 32'(bus.mem_wdata), 32'(d0 + 8'(i)));
    end
    bus.s_valid = 1'b0;
    check("commit_ready", 32'(bus.s_ready), 0);
    bus.rd_burst_done = rd_at_commit;
    step();
    bus.rd_burst_done = 1'b0;
    check("bstart",      32'(bus.burst_start), 1);
    check("bbase",       32'(bus.burst_base), addr0);
    check("outstanding", 32'(bus.outstanding), exp_out);
    check("post_we",     32'(bus.mem_we), 0);
    check("idle_ready",  32'(bus.s_ready), 0);
    step();
    check("bstart_pulse", 32'(bus.burst_start), 0);
    check("bbase_hold",   32'(bus.burst_base), addr0);
  endtask

  initial begin
    rst               = 1'b1;
    bus.s_valid       = 1'b0;
    bus.s_data        = '0;
    bus.rd_burst_done = 1'b0;
    repeat (3) step();
    check_reset("reset");

    // Test 1: first burst 0x01..0x0A at addresses 0..9.
    rst = 1'b0;
    step();
    check("idle_to_fill", 32'(bus.s_ready), 1);
    write_burst(8'h01, 0, 1'b0, 1);

    // Test 2: fill the buffer, then free one slot.
    for (int unsigned k = 1; k < 10; k++)
      write_burst(8'(16 * k), 10 * k, 1'b0, k + 1);
    repeat (5) step();
    check("full_ready", 32'(bus.s_ready), 0);
    check("full_count", 32'(bus.outstanding), 10);
    bus.rd_burst_done = 1'b1;
    step();
    bus.rd_burst_done = 1'b0;
    check("credit_count", 32'(bus.outstanding), 9);
    check("credit_ready_lag", 32'(bus.s_ready), 0);
    step();
    check("ready_after_credit", 32'(bus.s_ready), 1);
    write_burst(8'hA0, 0, 1'b0, 10);

    // Test 3: credit on the commit edge with 3 outstanding.
    bus.rd_burst_done = 1'b1;
    repeat (7) step();
    bus.rd_burst_done = 1'b0;
    check("drain_to_3", 32'(bus.outstanding), 3);
    write_burst(8'hB0, 10, 1'b1, 3);
    check("simul_err", 32'(bus.err), 0);

    // Test 4: credit underflow.
    bus.rd_burst_done = 1'b1;
    repeat (3) step();
    bus.rd_burst_done = 1'b0;
    check("drain_to_0", 32'(bus.outstanding), 0);
    check("drain_err", 32'(bus.err), 0);
    bus.rd_burst_done = 1'b1;
    step();
    bus.rd_burst_done = 1'b0;
    check("underflow_count", 32'(bus.outstanding), 0);
    check("underflow_err", 32'(bus.err), 1);
    repeat (5) step();
    check("err_sticky", 32'(bus.err), 1);

    // Test 5: reset after 4 accepted words of a burst at address 20.
    for (int unsigned i = 0; i < 4; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hC0 + 8'(i);
      step();
    end
    check("partial_addr", 32'(bus.mem_addr), 23);
    bus.s_valid = 1'b0;
    rst = 1'b1;
    step();
    check_reset("mid_reset");
    rst = 1'b0;
    write_burst(8'hD0, 0, 1'b0, 1);

    // Test 6: partial burst left idle.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int unsigned i = 0; i < 3; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hE0 + 8'(i);
      step();
      check("part_addr", 32'(bus.mem_addr), i);
    end
    bus.s_valid = 1'b0;
    step();
    check("part_idle_we", 32'(bus.mem_we), 0);
`ifdef BURST_WR_FLUSH_EN
    for (int n = 0; n < 40 && bus.mem_we !== 1'b1; n++) step();
    check("pad_start", 32'(bus.mem_we), 1);
    for (int unsigned i = 0; i < 7; i++) begin
      if (i != 0) step();
      check("pad_we",    32'(bus.mem_we), 1);
      check("pad_addr",  32'(bus.mem_addr), 3 + i);
      check("pad_data",  32'(bus.mem_wdata), 0);
      check("pad_ready", 32'(bus.s_ready), 0);
    end
    step();
    check("pad_bstart", 32'(bus.burst_start), 1);
    check("pad_bbase",  32'(bus.burst_base), 0);
    check("pad_outst",  32'(bus.outstanding), 1);
`else
    repeat (40) begin
      step();
      if (bus.mem_we === 1'b1) we_seen++;
      if (bus.burst_start === 1'b1) bs_seen++;
    end
    check("noflush_writes", we_seen, 0);
    check("noflush_bstart", bs_seen, 0);
    check("noflush_ready",  32'(bus.s_ready), 1);
    check("noflush_outst",  32'(bus.outstanding), 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
